// File: rtl/sddr_pkg.sv
// Shared types and constants for the SDDR word-to-line bridge.
package sddr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FILL_CMD  = 3'd1,
        ST_FILL_WAIT = 3'd2,
        ST_WB_CMD    = 3'd3,
        ST_WB_WAIT   = 3'd4,
        ST_RESP      = 3'd5
    } state_t;

    localparam int WORD_BITS         = 32;
    localparam int DEFAULT_LINE_BITS = 128;
    localparam int WORDS_PER_LINE    = DEFAULT_LINE_BITS / WORD_BITS;
    localparam int LINE_OFFSET_BITS  = 4;
    localparam int WORD_IDX_BITS     = LINE_OFFSET_BITS - 2;

endpackage

// File: rtl/sddr_line_merge.sv
// Replaces the enabled bytes of one word inside a line; all other bytes pass through.
module sddr_line_merge
    import sddr_pkg::*;
#(
    parameter int LINE_BITS = DEFAULT_LINE_BITS
) (
    input  logic [LINE_BITS-1:0]     line,
    input  logic [WORD_IDX_BITS-1:0] word_idx,
    input  logic [WORD_BITS-1:0]     wdata,
    input  logic [3:0]               be,
    output logic [LINE_BITS-1:0]     merged
);

    // NOTE: default assignment first so no path through this block infers a latch.
    always_comb begin
        merged = line;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                merged[int'(word_idx) * WORD_BITS + b * 8 +: 8] = wdata[b * 8 +: 8];
            end
        end
    end

endmodule

// File: rtl/sddr_word_bridge.sv
// CPU word port to SDDR line-command bridge with a one-line write-through read buffer.
module sddr_word_bridge
    import sddr_pkg::*;
#(
    parameter int ADDR_BITS      = 27,
    parameter int LINE_BITS      = DEFAULT_LINE_BITS,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                 cpu_clock_i,
    input  logic                 reset_i,
    input  logic                 cpu_req_valid_i,
    output logic                 cpu_req_ready_o,
    input  logic [ADDR_BITS-1:0] cpu_req_addr_i,
    input  logic                 cpu_req_write_i,
    input  logic [31:0]          cpu_req_wdata_i,
    input  logic [3:0]           cpu_req_be_i,
    output logic                 cpu_rsp_valid_o,
    output logic [31:0]          cpu_rsp_rdata_o,
    output logic                 cpu_rsp_error_o,
    input  logic                 flush_i,
    output logic                 mem_cmd_valid_o,
    input  logic                 mem_cmd_ack_i,
    output logic [ADDR_BITS-1:0] mem_cmd_address_o,
    output logic                 mem_cmd_write_o,
    output logic [LINE_BITS-1:0] mem_cmd_data_o,
    input  logic                 mem_rsp_ready_i,
    input  logic [LINE_BITS-1:0] mem_rsp_data_i
);

    localparam int TAG_BITS = ADDR_BITS - LINE_OFFSET_BITS;
    localparam int CNT_BITS = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    state_t                state;
    logic [ADDR_BITS-1:0]  req_addr;
    logic                  req_write;
    logic [31:0]           req_wdata;
    logic [3:0]            req_be;
    logic [LINE_BITS-1:0]  buf_data;
    logic [TAG_BITS-1:0]   buf_tag;
    logic                  buf_valid;
    logic [31:0]           rsp_rdata;
    logic                  rsp_error;
    logic [CNT_BITS-1:0]   wait_cnt;

    logic                     hit;
    logic                     timeout_hit;
    logic [WORD_IDX_BITS-1:0] merge_idx;
    logic [LINE_BITS-1:0]     merge_src;
    logic [LINE_BITS-1:0]     merged_line;
    logic                     unused_addr_bits;

    assign unused_addr_bits = ^cpu_req_addr_i[1:0];

    // A flush in the acceptance cycle forces a miss.
    assign hit = buf_valid && !flush_i && (buf_tag == cpu_req_addr_i[ADDR_BITS-1:LINE_OFFSET_BITS]);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt == CNT_BITS'(TIMEOUT_CYCLES));

    // The merger serves the write-hit path in IDLE and the fill-then-write path in FILL_WAIT.
    assign merge_idx = (state == ST_IDLE) ? cpu_req_addr_i[3:2] : req_addr[3:2];
    assign merge_src = (state == ST_FILL_WAIT) ? mem_rsp_data_i : buf_data;

    sddr_line_merge #(.LINE_BITS(LINE_BITS)) u_merge (
        .line     (merge_src),
        .word_idx (merge_idx),
        .wdata    ((state == ST_IDLE) ? cpu_req_wdata_i : req_wdata),
        .be       ((state == ST_IDLE) ? cpu_req_be_i : req_be),
        .merged   (merged_line)
    );

    assign cpu_req_ready_o   = (state == ST_IDLE) && !reset_i;
    assign cpu_rsp_valid_o   = (state == ST_RESP);
    assign cpu_rsp_rdata_o   = (state == ST_RESP) ? rsp_rdata : '0;
    assign cpu_rsp_error_o   = (state == ST_RESP) && rsp_error;
    assign mem_cmd_valid_o   = (state == ST_FILL_CMD) || (state == ST_WB_CMD);
    assign mem_cmd_write_o   = (state == ST_WB_CMD);
    assign mem_cmd_address_o = mem_cmd_valid_o ? {req_addr[ADDR_BITS-1:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}} : '0;
    assign mem_cmd_data_o    = (state == ST_WB_CMD) ? buf_data : '0;

    // NOTE: every register here is state, so only non-blocking assignments are used.
    always_ff @(posedge cpu_clock_i) begin
        if (reset_i) begin
            state     <= ST_IDLE;
            req_addr  <= '0;
            req_write <= 1'b0;
            req_wdata <= '0;
            req_be    <= '0;
            buf_data  <= '0;
            buf_tag   <= '0;
            buf_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_error <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            if (flush_i) buf_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cpu_req_valid_i) begin
                        req_addr  <= cpu_req_addr_i;
                        req_write <= cpu_req_write_i;
                        req_wdata <= cpu_req_wdata_i;
                        req_be    <= cpu_req_be_i;
                        rsp_rdata <= '0;
                        rsp_error <= 1'b0;
                        if (cpu_req_write_i && cpu_req_be_i == 4'b0000) begin
                            state <= ST_RESP;
                        end else if (hit && !cpu_req_write_i) begin
                            rsp_rdata <= buf_data[int'(cpu_req_addr_i[3:2]) * WORD_BITS +: WORD_BITS];
                            state     <= ST_RESP;
                        end else if (hit) begin
                            buf_data <= merged_line;
                            state    <= ST_WB_CMD;
                        end else begin
                            state <= ST_FILL_CMD;
                        end
                    end
                end
                ST_FILL_CMD: begin
                    if (mem_cmd_ack_i) begin
                        wait_cnt <= '0;
                        state    <= ST_FILL_WAIT;
                    end
                end
                ST_FILL_WAIT: begin
                    if (mem_rsp_ready_i) begin
                        buf_tag   <= req_addr[ADDR_BITS-1:LINE_OFFSET_BITS];
                        buf_valid <= !flush_i;
                        if (req_write) begin
                            buf_data <= merged_line;
                            state    <= ST_WB_CMD;
                        end else begin
                            buf_data  <= mem_rsp_data_i;
                            rsp_rdata <= mem_rsp_data_i[int'(req_addr[3:2]) * WORD_BITS +: WORD_BITS];
                            state     <= ST_RESP;
                        end
                    end else if (timeout_hit) begin
                        buf_valid <= 1'b0;
                        rsp_error <= 1'b1;
                        state     <= ST_RESP;
                    end else if (wait_cnt < CNT_BITS'(TIMEOUT_CYCLES)) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_WB_CMD: begin
                    if (mem_cmd_ack_i) begin
                        wait_cnt <= '0;
                        state    <= ST_WB_WAIT;
                    end
                end
                ST_WB_WAIT: begin
                    if (mem_rsp_ready_i) begin
                        state <= ST_RESP;
                    end else if (timeout_hit) begin
                        buf_valid <= 1'b0;
                        rsp_error <= 1'b1;
                        state     <= ST_RESP;
                    end else if (wait_cnt < CNT_BITS'(TIMEOUT_CYCLES)) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sddr_word_bridge.sv
// Directed-vector bench for sddr_word_bridge, with the bench acting as the SDDR controller.
module tb_sddr_word_bridge;

    logic         cpu_clock_i = 1'b0;
    logic         reset_i = 1'b1;
    logic         cpu_req_valid_i = 1'b0;
    logic         cpu_req_ready_o;
    logic [26:0]  cpu_req_addr_i = '0;
    logic         cpu_req_write_i = 1'b0;
    logic [31:0]  cpu_req_wdata_i = '0;
    logic [3:0]   cpu_req_be_i = '0;
    logic         cpu_rsp_valid_o;
    logic [31:0]  cpu_rsp_rdata_o;
    logic         cpu_rsp_error_o;
    logic         flush_i = 1'b0;
    logic         mem_cmd_valid_o;
    logic         mem_cmd_ack_i = 1'b0;
    logic [26:0]  mem_cmd_address_o;
    logic         mem_cmd_write_o;
    logic [127:0] mem_cmd_data_o;
    logic         mem_rsp_ready_i = 1'b0;
    logic [127:0] mem_rsp_data_i = '0;

    int vectors = 0;
    int miscompares = 0;
    int cmd_count = 0;
    int rsp_count = 0;

    sddr_word_bridge #(.ADDR_BITS(27), .LINE_BITS(128), .TIMEOUT_CYCLES(16)) dut (
        .cpu_clock_i       (cpu_clock_i),
        .reset_i           (reset_i),
        .cpu_req_valid_i   (cpu_req_valid_i),
        .cpu_req_ready_o   (cpu_req_ready_o),
        .cpu_req_addr_i    (cpu_req_addr_i),
        .cpu_req_write_i   (cpu_req_write_i),
        .cpu_req_wdata_i   (cpu_req_wdata_i),
        .cpu_req_be_i      (cpu_req_be_i),
        .cpu_rsp_valid_o   (cpu_rsp_valid_o),
        .cpu_rsp_rdata_o   (cpu_rsp_rdata_o),
        .cpu_rsp_error_o   (cpu_rsp_error_o),
        .flush_i           (flush_i),
        .mem_cmd_valid_o   (mem_cmd_valid_o),
        .mem_cmd_ack_i     (mem_cmd_ack_i),
        .mem_cmd_address_o (mem_cmd_address_o),
        .mem_cmd_write_o   (mem_cmd_write_o),
        .mem_cmd_data_o    (mem_cmd_data_o),
        .mem_rsp_ready_i   (mem_rsp_ready_i),
        .mem_rsp_data_i    (mem_rsp_data_i)
    );

    always #5 cpu_clock_i = ~cpu_clock_i;

    always @(posedge cpu_clock_i) begin
        if (mem_cmd_valid_o && mem_cmd_ack_i) cmd_count++;
        if (cpu_rsp_valid_o) rsp_count++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000 ns, required to finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge cpu_clock_i);
        #1;
    endtask

    task automatic cpu_req(input logic [26:0] addr, input logic wr, input logic [31:0] wdata,
                           input logic [3:0] be, input logic flush);
        int n = 0;
        cpu_req_valid_i = 1'b1;
        cpu_req_addr_i  = addr;
        cpu_req_write_i = wr;
        cpu_req_wdata_i = wdata;
        cpu_req_be_i    = be;
        while (!cpu_req_ready_o && n < 40) begin
            tick();
            n++;
        end
        if (!cpu_req_ready_o) check("req_ready_timeout", cpu_req_ready_o, 1'b1);
        flush_i = flush;
        tick();
        flush_i = 1'b0;
        cpu_req_valid_i = 1'b0;
    endtask

    // Waits for a line command, checks it, optionally stalls the ack, then optionally completes it.
    task automatic serve_cmd(input string tag, input logic [26:0] exp_addr, input logic exp_write,
                             input logic chk_data, input logic [127:0] exp_data, input int ack_delay,
                             input logic give_rsp, input logic [127:0] rsp_line);
        int n = 0;
        logic stable = 1'b1;
        logic [26:0] snap_addr;
        logic [127:0] snap_data;
        while (!mem_cmd_valid_o && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_cmd_valid"}, mem_cmd_valid_o, 1'b1);
        if (!mem_cmd_valid_o) return;
        check({tag, "_cmd_addr"}, mem_cmd_address_o, exp_addr);
        check({tag, "_cmd_write"}, mem_cmd_write_o, exp_write);
        if (chk_data) check({tag, "_cmd_data"}, mem_cmd_data_o, exp_data);
        snap_addr = mem_cmd_address_o;
        snap_data = mem_cmd_data_o;
        for (int i = 0; i < ack_delay; i++) begin
            tick();
            if (mem_cmd_valid_o !== 1'b1 || mem_cmd_address_o !== snap_addr ||
                mem_cmd_data_o !== snap_data || mem_cmd_write_o !== exp_write ||
                cpu_req_ready_o !== 1'b0) stable = 1'b0;
        end
        if (ack_delay > 0) check({tag, "_held_stable"}, stable, 1'b1);
        mem_cmd_ack_i = 1'b1;
        tick();
        mem_cmd_ack_i = 1'b0;
        if (give_rsp) begin
            mem_rsp_data_i  = rsp_line;
            mem_rsp_ready_i = 1'b1;
            tick();
            mem_rsp_ready_i = 1'b0;
        end
    endtask

    task automatic wait_rsp(input string tag, input logic [31:0] exp_rdata, input logic exp_err);
        int n = 0;
        while (!cpu_rsp_valid_o && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_rsp_valid"}, cpu_rsp_valid_o, 1'b1);
        if (!cpu_rsp_valid_o) return;
        check({tag, "_rsp_rdata"}, cpu_rsp_rdata_o, exp_rdata);
        check({tag, "_rsp_error"}, cpu_rsp_error_o, exp_err);
        tick();
    endtask

    task automatic hit_read(input string tag, input logic [26:0] addr, input logic [31:0] exp_rdata);
        int c0 = cmd_count;
        cpu_req(addr, 1'b0, '0, 4'h0, 1'b0);
        check({tag, "_rsp_next_cycle"}, cpu_rsp_valid_o, 1'b1);
        check({tag, "_rdata"}, cpu_rsp_rdata_o, exp_rdata);
        tick();
        check({tag, "_rsp_one_cycle"}, cpu_rsp_valid_o, 1'b0);
        check({tag, "_no_mem_cmd"}, cmd_count, c0);
    endtask

    initial begin
        logic [127:0] line1, line1w, line2, line2w, line3, line4;
        int c0, r0, n;
        line1  = {32'h33333333, 32'h22222222, 32'hCAFEF00D, 32'h11110000};
        line1w = {32'h33333333, 32'h22222222, 32'hCA22F044, 32'h11110000};
        line2  = {32'h44444444, 32'h55555555, 32'h66666666, 32'h77777777};
        line2w = {32'h44444444, 32'h55555555, 32'h66666666, 32'hDEADBEEF};
        line3  = {32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0};
        line4  = {32'hB3B3B3B3, 32'hB2B2B2B2, 32'hB1B1B1B1, 32'hB0B0B0B0};

        repeat (3) tick();
        check("reset_ready", cpu_req_ready_o, 1'b0);
        check("reset_rsp_valid", cpu_rsp_valid_o, 1'b0);
        check("reset_cmd_valid", mem_cmd_valid_o, 1'b0);
        check("reset_cmd_addr", mem_cmd_address_o, 27'h0);
        check("reset_cmd_data", mem_cmd_data_o, 128'h0);
        reset_i = 1'b0;
        #1;
        check("post_reset_ready", cpu_req_ready_o, 1'b1);

        // Read miss, then a hit in the same line.
        cpu_req(27'h0000104, 1'b0, '0, 4'h0, 1'b0);
        serve_cmd("rd_miss", 27'h0000100, 1'b0, 1'b0, '0, 0, 1'b1, line1);
        wait_rsp("rd_miss", 32'hCAFEF00D, 1'b0);
        hit_read("rd_hit", 27'h0000108, 32'h22222222);

        // Write hit with partial byte enables.
        r0 = rsp_count;
        cpu_req(27'h0000104, 1'b1, 32'h11223344, 4'b0101, 1'b0);
        serve_cmd("wr_hit", 27'h0000100, 1'b1, 1'b1, line1w, 0, 1'b1, '0);
        wait_rsp("wr_hit", 32'h0, 1'b0);
        check("wr_hit_one_rsp", rsp_count - r0, 1);
        hit_read("rd_after_wr", 27'h0000104, 32'hCA22F044);

        // Write with no byte enables: immediate response, no memory traffic.
        c0 = cmd_count;
        cpu_req(27'h0000100, 1'b1, 32'hFFFFFFFF, 4'b0000, 1'b0);
        check("be0_rsp_next_cycle", cpu_rsp_valid_o, 1'b1);
        tick();
        check("be0_no_mem_cmd", cmd_count, c0);

        // Write miss with full enables still fills first; write-back ack is stalled 10 cycles.
        c0 = cmd_count;
        r0 = rsp_count;
        cpu_req(27'h0000200, 1'b1, 32'hDEADBEEF, 4'hF, 1'b0);
        serve_cmd("wr_miss_fill", 27'h0000200, 1'b0, 1'b0, '0, 0, 1'b1, line2);
        serve_cmd("wr_miss_wb", 27'h0000200, 1'b1, 1'b1, line2w, 10, 1'b1, '0);
        wait_rsp("wr_miss", 32'h0, 1'b0);
        check("wr_miss_two_cmds", cmd_count - c0, 2);
        check("wr_miss_one_rsp", rsp_count - r0, 1);

        // Fill that never completes times out.
        cpu_req(27'h0000300, 1'b0, '0, 4'h0, 1'b0);
        serve_cmd("to", 27'h0000300, 1'b0, 1'b0, '0, 0, 1'b0, '0);
        n = 0;
        while (!cpu_rsp_valid_o && n < 40) begin
            tick();
            n++;
        end
        check("to_latency_in_window", (n >= 16 && n <= 18), 1'b1);
        check("to_rsp_valid", cpu_rsp_valid_o, 1'b1);
        check("to_rsp_error", cpu_rsp_error_o, 1'b1);
        check("to_rsp_rdata", cpu_rsp_rdata_o, 32'h0);
        tick();
        r0 = rsp_count;
        mem_rsp_data_i  = line2;
        mem_rsp_ready_i = 1'b1;
        tick();
        mem_rsp_ready_i = 1'b0;
        check("late_rsp_no_pulse", cpu_rsp_valid_o, 1'b0);
        tick();
        check("late_rsp_no_count", rsp_count, r0);

        // Line 0x200 was valid before the timeout; it must now miss.
        cpu_req(27'h0000208, 1'b0, '0, 4'h0, 1'b0);
        serve_cmd("post_to", 27'h0000200, 1'b0, 1'b0, '0, 0, 1'b1, line3);
        wait_rsp("post_to", 32'hA2A2A2A2, 1'b0);

        // Flush in the acceptance cycle turns a would-be hit into a miss.
        cpu_req(27'h0000204, 1'b0, '0, 4'h0, 1'b1);
        serve_cmd("flush", 27'h0000200, 1'b0, 1'b0, '0, 0, 1'b1, line4);
        wait_rsp("flush", 32'hB1B1B1B1, 1'b0);

        // Reset while waiting for a fill: no response, stray completion ignored.
        r0 = rsp_count;
        cpu_req(27'h0000400, 1'b0, '0, 4'h0, 1'b0);
        serve_cmd("rst", 27'h0000400, 1'b0, 1'b0, '0, 0, 1'b0, '0);
        tick();
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        #1;
        check("rst_ready", cpu_req_ready_o, 1'b1);
        check("rst_cmd_valid", mem_cmd_valid_o, 1'b0);
        mem_rsp_data_i  = line1;
        mem_rsp_ready_i = 1'b1;
        tick();
        mem_rsp_ready_i = 1'b0;
        check("rst_stray_no_pulse", cpu_rsp_valid_o, 1'b0);
        repeat (2) tick();
        check("rst_no_rsp", rsp_count, r0);
        check("rst_idle", cpu_req_ready_o, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
